// File: rtl/laser_pkg.sv
// Shared laser definitions: state encoding, quadrant type and the default beam
// geometry that the render layers also use for laser_r.
package laser_pkg;
  localparam int LASER_R_W            = 5;
  localparam int LASER_MAX_R          = 20;
  localparam int LASER_COOLDOWN_STEPS = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRING   = 2'd1,
    COOLDOWN = 2'd2
  } laser_state_t;

  typedef logic [1:0] quadrant_t;
endpackage

// File: rtl/laser_if.sv
// Laser control bus: player/game-step inputs and the beam outputs fanned out to
// the render layers. master drives the inputs, slave is the controller.
interface laser_if #(parameter int R_W = laser_pkg::LASER_R_W);
  import laser_pkg::*;

  logic            step;
  logic            fire;
  quadrant_t       quadrant_sel;
  logic            hit;
  logic            laser_active;
  logic [R_W-1:0]  laser_r;
  quadrant_t       laser_quadrant;
  logic            laser_ready;
  logic            shot_done;
  logic            shot_hit;

  modport master (
    output step, fire, quadrant_sel, hit,
    input  laser_active, laser_r, laser_quadrant, laser_ready, shot_done, shot_hit
  );

  modport slave (
    input  step, fire, quadrant_sel, hit,
    output laser_active, laser_r, laser_quadrant, laser_ready, shot_done, shot_hit
  );
endinterface

// File: rtl/laser_cooldown_timer.sv
// Step-gated cooldown counter. expired flags the enabled step that brings the
// count to LIMIT, so the owner can leave cooldown on that same edge.
module laser_cooldown_timer #(
  parameter int LIMIT = laser_pkg::LASER_COOLDOWN_STEPS
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic step,
  output logic expired
);
  logic [7:0] count;

  assign expired = en && step && (count == 8'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              count <= '0;
    else if (clear)       count <= '0;
    else if (en && step)  count <= count + 8'd1;
  end
endmodule

// File: rtl/laser_ctrl.sv
// Laser shot sequencer: IDLE -> FIRING (beam grows one ring per step) -> COOLDOWN.
// Define LASER_AUTOFIRE_EN to fire on the fire level instead of its rising edge.
module laser_ctrl
  import laser_pkg::*;
#(
  parameter int R_W            = LASER_R_W,
  parameter int MAX_R          = LASER_MAX_R,
  parameter int COOLDOWN_STEPS = LASER_COOLDOWN_STEPS
) (
  input  logic   clk,
  input  logic   rst,
  laser_if.slave bus
);
  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_FIRING   = FIRING;
  localparam logic [1:0] S_COOLDOWN = COOLDOWN;

  logic [1:0]     state;
  logic           active_q, ready_q, done_q, hit_q;
  logic [R_W-1:0] r_q;
  quadrant_t      quad_q;
  logic           trig, at_max, shot_end, cd_expired;

`ifdef LASER_AUTOFIRE_EN
  assign trig = bus.fire;
`else
  logic fire_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fire_q <= 1'b0;
    else     fire_q <= bus.fire;
  end
  assign trig = bus.fire & ~fire_q;
`endif

  assign at_max   = (r_q == R_W'(MAX_R));
  // hit wins over a coincident step, so the beam never advances on a hit edge
  assign shot_end = (state == S_FIRING) && (bus.hit || (bus.step && at_max));

  laser_cooldown_timer #(.LIMIT(COOLDOWN_STEPS)) u_cooldown (
    .clk     (clk),
    .rst     (rst),
    .clear   (shot_end),
    .en      (state == S_COOLDOWN),
    .step    (bus.step),
    .expired (cd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      active_q <= 1'b0;
      r_q      <= '0;
      quad_q   <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (trig) begin
          state    <= S_FIRING;
          active_q <= 1'b1;
          ready_q  <= 1'b0;
          r_q      <= '0;
          quad_q   <= bus.quadrant_sel;
        end
        S_FIRING: begin
          if (shot_end) begin
            state    <= S_COOLDOWN;
            active_q <= 1'b0;
            r_q      <= '0;
            done_q   <= 1'b1;
            hit_q    <= bus.hit;
          end else if (bus.step) begin
            r_q <= r_q + 1'b1;
          end
        end
        S_COOLDOWN: if (cd_expired) begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          active_q <= 1'b0;
          r_q      <= '0;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.laser_active   = active_q;
  assign bus.laser_r        = r_q;
  assign bus.laser_quadrant = quad_q;
  assign bus.laser_ready    = ready_q;
  assign bus.shot_done      = done_q;
  assign bus.shot_hit       = hit_q;
endmodule

// File: tb/tb_laser_ctrl.sv
// Directed bench for laser_ctrl: a shot-level reference model checked every
// cycle, plus hand-computed checkpoints along the directed sequence.
module tb_laser_ctrl;
  import laser_pkg::*;

  localparam int R_W   = 5;
  localparam int MAX_R = 20;
  localparam int CD    = 8;
`ifdef LASER_AUTOFIRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  laser_if #(.R_W(R_W)) bus ();

  laser_ctrl #(.R_W(R_W), .MAX_R(MAX_R), .COOLDOWN_STEPS(CD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what a player would observe shot by shot.
  bit m_ready = 1, m_active = 0, m_done = 0, m_hit = 0, m_fire_prev = 0;
  int m_r = 0, m_quad = 0, m_cool = 0;

  always @(posedge clk or posedge rst) begin
    bit trig;
    if (rst) begin
      m_ready = 1; m_active = 0; m_done = 0; m_hit = 0; m_fire_prev = 0;
      m_r = 0; m_quad = 0; m_cool = 0;
    end else begin
      trig = AUTO ? bus.fire : (bus.fire && !m_fire_prev);
      m_fire_prev = bus.fire;
      m_done = 0;
      if (m_ready) begin
        if (trig) begin
          m_ready = 0; m_active = 1; m_r = 0; m_quad = int'(bus.quadrant_sel);
        end
      end else if (m_active) begin
        if (bus.hit || (bus.step && m_r == MAX_R)) begin
          m_active = 0; m_r = 0; m_done = 1; m_hit = bus.hit; m_cool = 0;
        end else if (bus.step) begin
          m_r = m_r + 1;
        end
      end else if (bus.step) begin
        m_cool = m_cool + 1;
        if (m_cool == CD) m_ready = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("active", int'(bus.laser_active), int'(m_active));
    chk("r",      int'(bus.laser_r),      m_r);
    chk("quad",   int'(bus.laser_quadrant), m_quad);
    chk("ready",  int'(bus.laser_ready),  int'(m_ready));
    chk("done",   int'(bus.shot_done),    int'(m_done));
    chk("hit",    int'(bus.shot_hit),     int'(m_hit));
    if (bus.shot_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic stp(input int n);
    for (int i = 0; i < n; i++) begin
      bus.step = 1'b1; tick(); bus.step = 1'b0; tick();
    end
  endtask

  initial begin
    int d0;
    bus.step = 0; bus.fire = 0; bus.hit = 0; bus.quadrant_sel = 2'd0;
    #12 rst = 1'b0;
    tick();
    chk("rst_active", int'(bus.laser_active), 0);
    chk("rst_ready",  int'(bus.laser_ready), 1);
    chk("rst_r",      int'(bus.laser_r), 0);

    // shot 1: quadrant 2, runs to range
    bus.quadrant_sel = 2'd2; bus.fire = 1'b1; tick();
    chk("s1_active", int'(bus.laser_active), 1);
    chk("s1_quad",   int'(bus.laser_quadrant), 2);
    chk("s1_r",      int'(bus.laser_r), 0);
    chk("s1_ready",  int'(bus.laser_ready), 0);
    bus.fire = 1'b0; tick();
    d0 = done_cnt;
    stp(10);
    chk("s1_r10", int'(bus.laser_r), 10);
    bus.quadrant_sel = 2'd3; bus.fire = 1'b1; tick(); bus.fire = 1'b0; tick();
    bus.fire = 1'b1; tick(); bus.fire = 1'b0;
    stp(10);
    chk("s1_r20", int'(bus.laser_r), 20);
    chk("s1_quad_kept", int'(bus.laser_quadrant), 2);
    bus.step = 1'b1; tick(); bus.step = 1'b0;
    chk("s1_done",   int'(bus.shot_done), 1);
    chk("s1_hit",    int'(bus.shot_hit), 0);
    chk("s1_off",    int'(bus.laser_active), 0);
    tick();
    chk("s1_done_once", done_cnt - d0, 1);
    stp(3);
    bus.fire = 1'b1; tick(); bus.fire = 1'b0; tick();
    stp(4);
    chk("s1_cd7", int'(bus.laser_ready), 0);
    stp(1);
    chk("s1_ready_back", int'(bus.laser_ready), 1);
    chk("s1_no_refire", int'(bus.laser_active), 0);
    bus.hit = 1'b1; tick(); bus.hit = 1'b0; tick();
    chk("idle_hit_ignored", int'(bus.laser_ready), 1);

    // shot 2: quadrant 1, ended by hit coincident with step at r=5
    bus.quadrant_sel = 2'd1; bus.fire = 1'b1; tick(); bus.fire = 1'b0;
    stp(5);
    chk("s2_r5", int'(bus.laser_r), 5);
    bus.step = 1'b1; bus.hit = 1'b1; tick(); bus.step = 1'b0; bus.hit = 1'b0;
    chk("s2_r0",     int'(bus.laser_r), 0);
    chk("s2_off",    int'(bus.laser_active), 0);
    chk("s2_done",   int'(bus.shot_done), 1);
    chk("s2_hit",    int'(bus.shot_hit), 1);
    stp(CD);
    chk("s2_ready", int'(bus.laser_ready), 1);

    // shot 3: fire held through the whole shot and cooldown
    bus.quadrant_sel = 2'd0; bus.fire = 1'b1; tick();
    chk("s3_active", int'(bus.laser_active), 1);
    chk("s2_hit_held", int'(bus.shot_hit), 1);
    stp(MAX_R + 1);
    chk("s3_hit", int'(bus.shot_hit), 0);
    stp(CD - 1);
    bus.step = 1'b1; tick(); bus.step = 1'b0;
    chk("s3_ready", int'(bus.laser_ready), 1);
    tick();
    chk("s3_held_refire", int'(bus.laser_active), AUTO ? 1 : 0);
    tick(); tick();
    chk("s3_held_hold", int'(bus.laser_active), AUTO ? 1 : 0);
    bus.fire = 1'b0; tick();
    if (!AUTO) begin
      bus.fire = 1'b1; tick(); bus.fire = 1'b0;
    end
    chk("s4_active", int'(bus.laser_active), 1);
    stp(10);
    chk("s4_r10", int'(bus.laser_r), 10);

    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk("arst_active", int'(bus.laser_active), 0);
    chk("arst_r",      int'(bus.laser_r), 0);
    chk("arst_quad",   int'(bus.laser_quadrant), 0);
    chk("arst_ready",  int'(bus.laser_ready), 1);
    chk("arst_hit",    int'(bus.shot_hit), 0);
    #1 rst = 1'b0;
    tick(); tick();
    chk("post_rst_ready", int'(bus.laser_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
